// File: rtl/muldiv_iter_if.sv
// Issue/retire bundle between the execute stage and the iterative multiply/divide unit.
// The core drives the request side; the unit drives the response side.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    modport master (
        output start_valid, op, a, b, flush, result_ready,
        input  start_ready, result, result_valid, busy
    );

    modport slave (
        input  start_valid, op, a, b, flush, result_ready,
        output start_ready, result, result_valid, busy
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: WIDTH shift-add / restoring-divide steps on magnitudes,
// followed by one sign-fix cycle; divide special cases may bypass straight to DONE.
module muldiv_iter #(
    parameter int WIDTH          = 32,
    parameter bit BYPASS_SPECIAL = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_iter_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   spec_res;
    logic [2:0]         op_q;
    logic               neg;
    logic               special;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    logic accept, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    always_comb begin
        accept   = bus.start_valid && bus.start_ready && !bus.flush;
        a_sgn    = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
        b_sgn    = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        a_neg    = a_sgn && bus.a[WIDTH-1];
        b_neg    = b_sgn && bus.b[WIDTH-1];
        div_zero = bus.op[2] && (bus.b == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    end

    // Multiply keeps the multiplier in acc's low half and shifts right; divide shifts left
    // with the partial remainder in the high half and quotient bits entering at bit 0.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = rem_shift >= {1'b0, mag_b};
        div_sub   = rem_shift[WIDTH-1:0] - mag_b;
    end

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fixed;
    always_comb begin
        prod_s = neg ? -acc : acc;
        fixed  = prod_s[WIDTH-1:0];
        if (special)
            fixed = spec_res;
        else if (op_q[2])
            fixed = neg_if(op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0], neg);
        else if (op_q[1:0] != 2'b00)
            fixed = prod_s[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= bus.op;
            mag_b    <= neg_if(bus.b, b_neg);
            acc      <= {{WIDTH{1'b0}}, neg_if(bus.a, a_neg)};
            neg      <= (bus.op[2] && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
            special  <= div_zero || div_ovf;
            spec_res <= div_zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
        end else if (state == CALC) begin
            if (op_q[2])
                acc <= div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1}
                              : {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc <= {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.start_ready  <= 1'b1;
        end else if (bus.flush) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.start_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.start_valid) begin
                    cnt             <= '0;
                    bus.busy        <= 1'b1;
                    bus.start_ready <= 1'b0;
                    state           <= (BYPASS_SPECIAL && (div_zero || div_ovf)) ? DONE : CALC;
                end
                CALC: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    bus.result       <= fixed;
                    bus.result_valid <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    // Bypassed special cases arrive here without a result yet.
                    if (!bus.result_valid) begin
                        bus.result       <= spec_res;
                        bus.result_valid <= 1'b1;
                    end else if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        bus.busy         <= 1'b0;
                        bus.start_ready  <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: 32-bit units with and without special-case bypass
// and an 8-bit unit, checked against hand-computed RV32M results and latencies.
module tb_muldiv_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_iter_if #(.WIDTH(32)) m0 ();
    muldiv_iter_if #(.WIDTH(32)) m1 ();
    muldiv_iter_if #(.WIDTH(8))  m2 ();

    muldiv_iter #(.WIDTH(32), .BYPASS_SPECIAL(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));
    muldiv_iter #(.WIDTH(32), .BYPASS_SPECIAL(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));
    muldiv_iter #(.WIDTH(8),  .BYPASS_SPECIAL(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input logic sv, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        case (u)
            0: begin m0.start_valid = sv; m0.op = op; m0.a = a; m0.b = b; end
            1: begin m1.start_valid = sv; m1.op = op; m1.a = a; m1.b = b; end
            default: begin m2.start_valid = sv; m2.op = op; m2.a = a[7:0]; m2.b = b[7:0]; end
        endcase
    endtask

    task automatic set_rr(input int u, input logic v);
        case (u)
            0: m0.result_ready = v;
            1: m1.result_ready = v;
            default: m2.result_ready = v;
        endcase
    endtask

    function automatic logic vld_of(input int u);
        case (u)
            0: return m0.result_valid;
            1: return m1.result_valid;
            default: return m2.result_valid;
        endcase
    endfunction

    function automatic logic [31:0] res_of(input int u);
        case (u)
            0: return m0.result;
            1: return m1.result;
            default: return {24'h0, m2.result};
        endcase
    endfunction

    // Issue, scramble operands after accept, wait for the result, then retire it.
    task automatic run_op(input int u, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        drive(u, 1'b1, op, a, b);
        @(posedge clk);
        #1 drive(u, 1'b0, 3'b011, 32'hDEADBEEF, 32'h12345678);
        lat = 0;
        while (!vld_of(u) && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("valid_seen", {31'b0, vld_of(u)}, 32'd1);
        res = res_of(u);
        @(negedge clk);
        set_rr(u, 1'b1);
        @(posedge clk);
        #1 set_rr(u, 1'b0);
    endtask

    task automatic vec(input string tag, input int u, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int lat;
        run_op(u, op, a, b, r, lat);
        check(tag, r, exp);
        if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        logic [31:0] r;
        int lat;
        logic seen;
        foreach (m0.a[i]) begin end
        drive(0, 1'b0, 3'b000, 0, 0);
        drive(1, 1'b0, 3'b000, 0, 0);
        drive(2, 1'b0, 3'b000, 0, 0);
        set_rr(0, 1'b0); set_rr(1, 1'b0); set_rr(2, 1'b0);
        m0.flush = 1'b0; m1.flush = 1'b0; m2.flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst_ready", {31'b0, m0.start_ready}, 1);
        check("rst_busy", {31'b0, m0.busy}, 0);
        check("rst_valid", {31'b0, m0.result_valid}, 0);
        check("rst_result", m0.result, 0);

        // Multiply, 32-bit
        vec("mul",    0, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        vec("mulh",   0, 3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        vec("mulhsu", 0, 3'b010, 32'd7, 32'hFFFFFFFD, 32'h00000006, 0);
        vec("mulhu",  0, 3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, 0);
        vec("mulhu_max", 0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);

        // Divide, 32-bit
        vec("div",  0, 3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 33);
        vec("rem",  0, 3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 0);
        vec("divu", 0, 3'b101, 32'hFFFFFFEC, 32'd3, 32'h5555554E, 0);
        vec("remu", 0, 3'b111, 32'hFFFFFFEC, 32'd3, 32'h00000002, 0);

        // Special cases, with and without bypass
        vec("divu0_byp",  0, 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        vec("rem0_byp",   0, 3'b110, 32'd5, 32'd0, 32'd5, 1);
        vec("divovf_byp", 0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        vec("removf_byp", 0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        vec("divu0_nb",   1, 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 33);
        vec("rem0_nb",    1, 3'b110, 32'd5, 32'd0, 32'd5, 33);
        vec("divovf_nb",  1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        vec("removf_nb",  1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
        vec("div_neg0_nb", 1, 3'b100, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 33);

        // Backpressure: hold the result in DONE while start_valid pulses
        @(negedge clk);
        drive(0, 1'b1, 3'b000, 32'd3, 32'd5);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'b000, 0, 0);
        lat = 0;
        while (!m0.result_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_valid_seen", {31'b0, m0.result_valid}, 1);
        check("bp_res", m0.result, 15);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(0, i[0], 3'b000, 32'd9, 32'd9);
            @(posedge clk);
            #1;
            check("bp_hold", m0.result, 15);
            check("bp_start_ready", {31'b0, m0.start_ready}, 0);
            check("bp_valid", {31'b0, m0.result_valid}, 1);
        end
        @(negedge clk);
        drive(0, 1'b0, 3'b000, 0, 0);
        m0.result_ready = 1'b1;
        @(posedge clk);
        #1 m0.result_ready = 1'b0;
        check("bp_ready_after_h", {31'b0, m0.start_ready}, 1);
        check("bp_valid_after_h", {31'b0, m0.result_valid}, 0);
        vec("bp_next", 0, 3'b000, 32'd6, 32'd7, 32'd42, 33);

        // Flush at CALC iteration 10
        @(negedge clk);
        drive(0, 1'b1, 3'b000, 32'd100, 32'd100);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'b000, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk) m0.flush = 1'b1;
        @(posedge clk);
        #1 m0.flush = 1'b0;
        check("flush_busy", {31'b0, m0.busy}, 0);
        check("flush_ready", {31'b0, m0.start_ready}, 1);
        check("flush_result_kept", m0.result, 42);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen = seen | m0.result_valid;
        end
        check("flush_no_valid", {31'b0, seen}, 0);
        vec("flush_next", 0, 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        drive(0, 1'b1, 3'b001, 32'h12345678, 32'h9ABCDEF0);
        @(posedge clk);
        #1 drive(0, 1'b0, 3'b000, 0, 0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", m0.result, 0);
        check("arst_valid", {31'b0, m0.result_valid}, 0);
        check("arst_busy", {31'b0, m0.busy}, 0);
        check("arst_ready", {31'b0, m0.start_ready}, 1);
        @(negedge clk) rst_n = 1'b1;
        vec("arst_next", 0, 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // 8-bit instance
        vec("w8_mulhsu", 2, 3'b010, 32'h80, 32'hFF, 32'h80, 9);
        vec("w8_divovf", 2, 3'b100, 32'h80, 32'hFF, 32'h80, 1);
        vec("w8_div",    2, 3'b100, 32'h81, 32'h02, 32'hC1, 9);
        vec("w8_rem",    2, 3'b110, 32'h81, 32'h02, 32'hFF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative, parametrised integer multiply/divide unit implementing the eight RISC-V M-extension operations. It sits beside the single-cycle ALU in the execute stage. The core issues an operation through a valid/ready handshake, stalls while the unit is busy, and retires the result through a second valid/ready handshake. Unlike the combinational ALU, it is multi-cycle: WIDTH shift-add or restoring-divide iterations plus one sign-fix cycle, with a single-cycle bypass for divide special cases.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 4 and even.
- BYPASS_SPECIAL, 1, when 1, divide-by-zero and signed-overflow divides finish in one cycle; when 0, they take the full latency.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  operation request.
- start_ready  out  1  high only in IDLE; a request is accepted on an edge where start_valid && start_ready.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a, b  in  WIDTH  operands (rs1, rs2).
- flush  in  1  synchronous abort.
- result  out  WIDTH  registered result.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state except IDLE.

## Operation
- **States:**
  - IDLE → CALC on accept.
  - IDLE → DONE on accept of a special case when BYPASS_SPECIAL=1.
  - CALC → FIX after WIDTH iterations.
  - FIX → DONE.
  - DONE → IDLE on result_valid && result_ready.
- **Operand latch:** op, a and b are latched on accept; input changes afterwards are ignored.
- **Signedness:**
  - MULH and DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned.
  - Signed operands are converted to magnitudes on accept; result sign = sign(a) XOR sign(b) for the product and quotient, and sign(a) for the remainder.
- **Multiply:**
  - Radix-2 shift-add over WIDTH cycles into a 2·WIDTH product register.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits of the correctly signed 2·WIDTH product.
- **Divide:**
  - Restoring division, one quotient bit per cycle, MSB first.
  - The quotient truncates toward zero; the remainder carries the dividend's sign.
- **Special cases** (detected on accept, from the raw operands):
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (DIV/REM with a = 1 followed by WIDTH-1 zeros, b = all-ones): DIV returns a; REM returns 0.
  - Both cases give identical results whatever the BYPASS_SPECIAL setting; the parameter changes latency only.
- **FIX cycle:** applies sign correction and selects the high/low half, then loads result.
- **DONE:** result and result_valid are held stable until the handshake completes.
- **Flush:**
  - In any state, the next edge goes to IDLE with result_valid=0 and result unchanged.
  - flush && start_valid in IDLE: flush wins and the request is not accepted.
  - flush in DONE together with result_ready: no handshake is counted.
- **Reset (rst_n low, at any time including mid-operation):** state=IDLE, result=0, result_valid=0, busy=0, start_ready=1, iteration counter=0. Partial work is discarded.

## Timing
- **Accept edge E0:** busy=1 and start_ready=0 from the cycle after E0.
- **Normal operations:** CALC occupies WIDTH cycles and FIX one cycle; result_valid rises after edge E0+WIDTH+1. With WIDTH=32 that is 33 cycles of busy before result_valid.
- **Special case, BYPASS_SPECIAL=1:** result_valid rises after edge E0+1.
- **Handshake edge H** (result_valid && result_ready): result_valid falls and start_ready rises after H. The earliest next accept is edge H+1, so there is no same-cycle retire-and-accept.
- **Iteration counter:** log2(WIDTH)+1 bits, counting 0..WIDTH-1, with no wrap beyond that range.

## Test plan
- **Multiply, WIDTH=32:**
  - Stimulus: a=7, b=0xFFFFFFFD.
  - MUL → 0xFFFFFFEB, MULH → 0xFFFFFFFF, MULHSU → 0x00000006, MULHU → 0x00000006.
  - For a=b=0xFFFFFFFF, MULHU → 0xFFFFFFFE.
  - result_valid exactly 33 cycles after accept.
- **Divide, WIDTH=32:**
  - Stimulus: a=0xFFFFFFEC, b=3.
  - DIV → 0xFFFFFFFA, REM → 0xFFFFFFFE, DIVU → 0x5555554E, REMU → 2.
- **Special cases:**
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - Valid 1 cycle after accept with BYPASS_SPECIAL=1, and 33 cycles with BYPASS_SPECIAL=0, with identical values.
- **Backpressure:**
  - Hold result_ready=0 for 10 cycles in DONE → result stable, start_ready=0, and start_valid pulses ignored.
  - Raise result_ready → start_ready=1 the next cycle; an op accepted at H+1 completes correctly.
- **Abort:**
  - Assert flush at CALC iteration 10 → IDLE next cycle and no result_valid.
  - Separately, drop rst_n mid-CALC → all outputs return to their reset values immediately.
  - In both cases a following MUL 3×5 → 15.
- **WIDTH=8 instance:**
  - MULHSU a=0x80, b=0xFF → 0x80.
  - DIV 0x80/0xFF → 0x80, valid 1 cycle after accept with BYPASS_SPECIAL=1.
  - DIV 0x81/0x02 → 0xC1, valid 9 cycles after accept.
